burst_cmd_scheduler: RTL and testbench
======================================

// Module: burst_cmd_scheduler
// PURPOSE
//  Sequences DDR5 commands for the burst storage slots of the back end. Watches each slot's state/type/address,
//  tracks open rows and timing per bank (4 bank groups x 4 banks), and emits one command (ACT/RD/WR/PRE) plus slot
//  index per command slot to the burst handler, which drives CA/CS_n. Row-hit-first, round-robin otherwise.
// PARAMETERS
//  NO_OF_BURSTS  4   number of burst storage slots (index width $clog2(NO_OF_BURSTS))
//  T_RCD         8   min cycles ACT -> RD/WR, same bank
//  T_RP          8   min cycles PRE -> ACT, same bank
//  T_RAS         20  min cycles ACT -> PRE, same bank
//  T_CCD         8   min cycles between any two RD/WR (covers 16-beat data burst)
//  CMD_GAP       2   min cycles between any two issued commands (2-cycle CA encoding)
// PORTS
//  clk                     in   1                    clock
//  rst_n                   in   1                    reset, asynchronous, active-low
//  in_burst_state          in   NO_OF_BURSTS x burst_states_type  per-slot state
//  in_burst_type           in   NO_OF_BURSTS x r_type             per-slot read/write
//  in_burst_address_bank   in   NO_OF_BURSTS x 2     per-slot bank
//  in_burst_address_bg     in   NO_OF_BURSTS x 2     per-slot bank group
//  in_burst_address_row    in   NO_OF_BURSTS x 16    per-slot row
//  out_burst_cmd           out  command              none/activate/read_cmd/write_cmd/precharge
//  out_cmd_index           out  $clog2(NO_OF_BURSTS) slot the command belongs to
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_burst_cmd=none, out_cmd_index=0, all 16 banks closed, all timers 0, rr_ptr=0,
//    all cas_done flags 0, gap/ccd counters 0. Reset mid-operation abandons any sequence; no command after release
//    until a slot is full.
//  - Commands are 1-cycle pulses: out_burst_cmd!=none for exactly one clk, then none for >= CMD_GAP-1 cycles.
//    out_cmd_index holds its value while out_burst_cmd==none.
//  - Eligible slot: in_burst_state==full and cas_done[i]==0. cas_done[i] set when RD/WR issued for slot i;
//    cleared when in_burst_state[i]!=full (slot moved to returning_data/empty).
//  - Per-bank state: CLOSED / OPEN(row). Timers count down to 0 and saturate:
//    ACT loads rcd=T_RCD, ras=T_RAS; PRE loads rp=T_RP. Bank id = {bg,bank}.
//  - Action per eligible slot (combinational, registered on issue):
//    bank OPEN, row match, rcd==0, ccd==0 -> RD (type read) or WR (type write);
//    bank OPEN, row mismatch, ras==0, no other eligible slot hits that open row -> PRE;
//    bank CLOSED, rp==0 -> ACT (bank -> OPEN(row)).
//  - Arbitration when gap counter==0: (1) lowest index >= rr_ptr (wrapping) among slots with a ready RD/WR;
//    (2) otherwise same wrap search among slots with ready ACT/PRE. rr_ptr <= issued index+1 (mod NO_OF_BURSTS)
//    only on RD/WR. Nothing ready -> none.
//  - After any command gap counter loads CMD_GAP-1; after RD/WR ccd loads T_CCD-1.
//  - Two slots, same bank, same row: one ACT serves both; each gets its own RD/WR, T_CCD apart.
//  - PRE: bank -> CLOSED, row tracking invalid. Auto-precharge not used (AP_bar=1).
//  - Slot leaving full before its CAS (illegal): flag cleared, bank state untouched, no assertion-free recovery needed.
//  - Timers are $clog2(max(T_*)+1) bits; no wrap (saturate at 0).
// STRUCTURE
//  - types_def (shared pkg): command, burst_states_type, r_type already there; add T_RCD/T_RP/T_RAS/T_CCD/CMD_GAP
//    defaults as localparams, plus bank_state_type {closed, open}.
//  - Sub-module bank_timer (x16, generate): holds open flag, open row, rcd/rp/ras counters; inputs act/pre strobes
//    + row; outputs is_open, open_row, rcd_ok, rp_ok, ras_ok.
//  - Top: eligibility/action decode, two wrap-priority pickers, gap/ccd counters, rr_ptr, cas_done, output regs.
// TESTING
//  - Reset: assert rst_n=0 mid-ACT -> out_burst_cmd=none, index 0 asynchronously; banks report closed.
//  - Slot0 full, read, bg1 bank2 row 0x0123 -> ACT idx0 at cycle t, read_cmd idx0 at t+8, nothing further.
//  - Slot0 then slot1 full, same bank/row, write -> one ACT, write_cmd idx0 at t+8, write_cmd idx1 at t+16.
//  - Bank open row 0x0010, slot2 full row 0x0020 same bank -> PRE no earlier than ACT+20, ACT row 0x0020 at PRE+8,
//    read_cmd at ACT+8.
//  - Slot1 ACT ready while slot3 row-hit RD ready -> read_cmd idx3 first, then activate idx1 >= CMD_GAP later.
//  - All 4 slots row-hits, rr_ptr=2 -> CAS order idx 2,3,0,1, each T_CCD apart; slot state->returning_data
//    clears cas_done.

Source files
------------

// File: rtl/burst_cmd_scheduler_pkg.sv
// Shared types and timing defaults for the DDR5 burst command scheduler.
package burst_cmd_scheduler_pkg;

    typedef enum logic [2:0] {none, activate, read_cmd, write_cmd, precharge} command;
    typedef enum logic [1:0] {empty, full, returning_data} burst_states_type;
    typedef enum logic {read, write} r_type;
    typedef enum logic {closed, open} bank_state_type;

    localparam int unsigned DEF_T_RCD   = 8;
    localparam int unsigned DEF_T_RP    = 8;
    localparam int unsigned DEF_T_RAS   = 20;
    localparam int unsigned DEF_T_CCD   = 8;
    localparam int unsigned DEF_CMD_GAP = 2;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/burst_cmd_scheduler_bank_timer.sv
// One DDR5 bank: open/closed state, open row, and saturating tRCD/tRP/tRAS countdowns.
module burst_cmd_scheduler_bank_timer
    import burst_cmd_scheduler_pkg::*;
#(
    parameter int unsigned T_RCD = DEF_T_RCD,
    parameter int unsigned T_RP  = DEF_T_RP,
    parameter int unsigned T_RAS = DEF_T_RAS,
    parameter int unsigned TW    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        act,
    input  logic        pre,
    input  logic [15:0] row,
    output logic        is_open,
    output logic [15:0] open_row,
    output logic        rcd_ok,
    output logic        rp_ok,
    output logic        ras_ok
);
    bank_state_type state_q;
    logic [15:0]    row_q;
    logic [TW-1:0]  rcd_q, rp_q, ras_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= closed;
            row_q   <= '0;
            rcd_q   <= '0;
            rp_q    <= '0;
            ras_q   <= '0;
        end else begin
            rcd_q <= (rcd_q != '0) ? rcd_q - TW'(1) : '0;
            rp_q  <= (rp_q != '0) ? rp_q - TW'(1) : '0;
            ras_q <= (ras_q != '0) ? ras_q - TW'(1) : '0;
            if (act) begin
                state_q <= open;
                row_q   <= row;
                rcd_q   <= TW'(T_RCD);
                ras_q   <= TW'(T_RAS);
            end
            if (pre) begin
                state_q <= closed;
                rp_q    <= TW'(T_RP);
            end
        end
    end

    assign is_open  = (state_q == open);
    assign open_row = row_q;
    // A command decided now appears next cycle, after one more decrement.
    assign rcd_ok   = (rcd_q <= TW'(1));
    assign rp_ok    = (rp_q <= TW'(1));
    assign ras_ok   = (ras_q <= TW'(1));

endmodule

// File: rtl/burst_cmd_scheduler.sv
// DDR5 command scheduler: one ACT/RD/WR/PRE per command slot for the burst storage slots,
// row hits first, round-robin between slots otherwise.
module burst_cmd_scheduler
    import burst_cmd_scheduler_pkg::*;
#(
    parameter int unsigned NO_OF_BURSTS = 4,
    parameter int unsigned T_RCD        = DEF_T_RCD,
    parameter int unsigned T_RP         = DEF_T_RP,
    parameter int unsigned T_RAS        = DEF_T_RAS,
    parameter int unsigned T_CCD        = DEF_T_CCD,
    parameter int unsigned CMD_GAP      = DEF_CMD_GAP
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  burst_states_type                in_burst_state        [NO_OF_BURSTS],
    input  r_type                           in_burst_type         [NO_OF_BURSTS],
    input  logic [1:0]                      in_burst_address_bank [NO_OF_BURSTS],
    input  logic [1:0]                      in_burst_address_bg   [NO_OF_BURSTS],
    input  logic [15:0]                     in_burst_address_row  [NO_OF_BURSTS],
    output command                          out_burst_cmd,
    output logic [$clog2(NO_OF_BURSTS)-1:0] out_cmd_index
);
    localparam int unsigned IW = $clog2(NO_OF_BURSTS);
    localparam int unsigned NB = 16;
    localparam int unsigned CW =
        $clog2(max4(T_RCD, T_RP, T_RAS, (T_CCD > CMD_GAP) ? T_CCD : CMD_GAP) + 1);

    logic [NB-1:0]           bank_open, rcd_ok, rp_ok, ras_ok, act_stb, pre_stb;
    logic [15:0]             open_row [NB];
    logic [3:0]              slot_bank [NO_OF_BURSTS];
    logic [NO_OF_BURSTS-1:0] elig, hit, rdwr_rdy, other_rdy, cas_done_q;
    logic                    row_kept, is_cas;
    logic [IW:0]             rdwr_pick, other_pick;
    logic [IW-1:0]           rr_q, idx_q, issue_idx;
    logic [CW-1:0]           gap_q, ccd_q;
    command                  cmd_q, issue_cmd;

    // First requesting slot at or after start, wrapping; MSB of the result flags a hit.
    function automatic logic [IW:0] pick(input logic [NO_OF_BURSTS-1:0] req,
                                         input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] sel, idx;
        found = 1'b0;
        sel   = start;
        for (int unsigned k = 0; k < NO_OF_BURSTS; k++) begin
            idx = IW'((32'(start) + k) % NO_OF_BURSTS);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        elig     = '0;
        hit      = '0;
        rdwr_rdy = '0;
        other_rdy = '0;
        row_kept = 1'b0;
        for (int i = 0; i < NO_OF_BURSTS; i++) begin
            slot_bank[i] = {in_burst_address_bg[i], in_burst_address_bank[i]};
            elig[i]      = (in_burst_state[i] == full) && !cas_done_q[i];
            hit[i]       = elig[i] && bank_open[slot_bank[i]] &&
                           (open_row[slot_bank[i]] == in_burst_address_row[i]);
        end
        for (int i = 0; i < NO_OF_BURSTS; i++) begin
            rdwr_rdy[i] = hit[i] && rcd_ok[slot_bank[i]] && (ccd_q == '0);
            // Never close a row another waiting slot still wants.
            row_kept = 1'b0;
            for (int j = 0; j < NO_OF_BURSTS; j++) begin
                if (j != i && hit[j] && slot_bank[j] == slot_bank[i]) row_kept = 1'b1;
            end
            if (bank_open[slot_bank[i]]) begin
                other_rdy[i] = elig[i] && !hit[i] && ras_ok[slot_bank[i]] && !row_kept;
            end else begin
                other_rdy[i] = elig[i] && rp_ok[slot_bank[i]];
            end
        end
    end

    always_comb begin
        rdwr_pick  = pick(rdwr_rdy, rr_q);
        other_pick = pick(other_rdy, rr_q);
        issue_cmd  = none;
        issue_idx  = idx_q;
        if (gap_q == '0) begin
            if (rdwr_pick[IW]) begin
                issue_idx = rdwr_pick[IW-1:0];
                issue_cmd = (in_burst_type[issue_idx] == read) ? read_cmd : write_cmd;
            end else if (other_pick[IW]) begin
                issue_idx = other_pick[IW-1:0];
                issue_cmd = bank_open[slot_bank[issue_idx]] ? precharge : activate;
            end
        end
        act_stb = '0;
        pre_stb = '0;
        if (issue_cmd == activate) act_stb[slot_bank[issue_idx]] = 1'b1;
        if (issue_cmd == precharge) pre_stb[slot_bank[issue_idx]] = 1'b1;
    end

    assign is_cas = (issue_cmd == read_cmd) || (issue_cmd == write_cmd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= none;
            idx_q      <= '0;
            rr_q       <= '0;
            gap_q      <= '0;
            ccd_q      <= '0;
            cas_done_q <= '0;
        end else begin
            cmd_q <= issue_cmd;
            idx_q <= issue_idx;
            gap_q <= (gap_q != '0) ? gap_q - CW'(1) : '0;
            ccd_q <= (ccd_q != '0) ? ccd_q - CW'(1) : '0;
            if (issue_cmd != none) gap_q <= CW'(CMD_GAP - 1);
            if (is_cas) begin
                ccd_q <= CW'(T_CCD - 1);
                rr_q  <= (issue_idx == IW'(NO_OF_BURSTS - 1)) ? '0 : issue_idx + IW'(1);
            end
            for (int i = 0; i < NO_OF_BURSTS; i++) begin
                if (in_burst_state[i] != full) cas_done_q[i] <= 1'b0;
                else if (is_cas && issue_idx == IW'(i)) cas_done_q[i] <= 1'b1;
            end
        end
    end

    assign out_burst_cmd = cmd_q;
    assign out_cmd_index = idx_q;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        burst_cmd_scheduler_bank_timer #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .TW    (CW)
        ) u_bank_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .act      (act_stb[b]),
            .pre      (pre_stb[b]),
            .row      (in_burst_address_row[issue_idx]),
            .is_open  (bank_open[b]),
            .open_row (open_row[b]),
            .rcd_ok   (rcd_ok[b]),
            .rp_ok    (rp_ok[b]),
            .ras_ok   (ras_ok[b])
        );
    end

endmodule

// File: tb/tb_burst_cmd_scheduler.sv
// Directed scoreboard bench for burst_cmd_scheduler: every issued command is matched against
// the expected command, slot index and cycle.
module tb_burst_cmd_scheduler;
    import burst_cmd_scheduler_pkg::*;

    typedef struct {
        command cmd;
        int     idx;
        int     cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    burst_states_type st  [4];
    r_type            ty  [4];
    logic [1:0]       bk  [4];
    logic [1:0]       bg  [4];
    logic [15:0]      row [4];
    command           out_burst_cmd;
    logic [1:0]       out_cmd_index;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    burst_cmd_scheduler #(
        .NO_OF_BURSTS (4)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_burst_state        (st),
        .in_burst_type         (ty),
        .in_burst_address_bank (bk),
        .in_burst_address_bg   (bg),
        .in_burst_address_row  (row),
        .out_burst_cmd         (out_burst_cmd),
        .out_cmd_index         (out_cmd_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input command cmd, input int idx, input int at);
        exp_t e;
        e.cmd = cmd;
        e.idx = idx;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic set_slot(input int i, input burst_states_type s, input r_type t,
                            input logic [1:0] g, input logic [1:0] b, input logic [15:0] r);
        st[i]  = s;
        ty[i]  = t;
        bg[i]  = g;
        bk[i]  = b;
        row[i] = r;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) set_slot(i, empty, read, 2'd0, 2'd0, 16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_slots();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Every visible command must be the next scoreboard entry, on its exact cycle.
    always @(negedge clk) begin
        if (rst_n && out_burst_cmd != none) begin
            if (sb.size() == 0) begin
                check("unexpected_cmd", int'(out_burst_cmd), int'(none));
            end else begin
                mon_e = sb.pop_front();
                check("cmd", int'(out_burst_cmd), int'(mon_e.cmd));
                check("idx", int'(out_cmd_index), mon_e.idx);
                check("cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int c;
        rst_n = 1'b0;
        clear_slots();
        repeat (3) @(negedge clk);
        check("rst_cmd", int'(out_burst_cmd), int'(none));
        check("rst_idx", int'(out_cmd_index), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single read to a closed bank
        c = cyc;
        set_slot(0, full, read, 2'd1, 2'd2, 16'h0123);
        expect_cmd(activate, 0, c + 1);
        expect_cmd(read_cmd, 0, c + 9);
        repeat (20) @(negedge clk);
        check("single_rd_drained", sb.size(), 0);
        st[0] = returning_data;
        repeat (2) @(negedge clk);
        st[0] = empty;

        // Async reset right after an ACT
        c = cyc;
        set_slot(1, full, read, 2'd2, 2'd0, 16'h0200);
        expect_cmd(activate, 1, c + 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cmd", int'(out_burst_cmd), int'(none));
        check("async_rst_idx", int'(out_cmd_index), 0);
        clear_slots();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        // Bank opened before reset must be closed again: expect a fresh ACT
        c = cyc;
        set_slot(0, full, read, 2'd1, 2'd2, 16'h0123);
        expect_cmd(activate, 0, c + 1);
        expect_cmd(read_cmd, 0, c + 9);
        repeat (15) @(negedge clk);
        check("post_rst_drained", sb.size(), 0);
        do_reset();

        // Two writes sharing one ACT
        c = cyc;
        set_slot(0, full, write, 2'd0, 2'd1, 16'h0456);
        set_slot(1, full, write, 2'd0, 2'd1, 16'h0456);
        expect_cmd(activate, 0, c + 1);
        expect_cmd(write_cmd, 0, c + 9);
        expect_cmd(write_cmd, 1, c + 17);
        repeat (25) @(negedge clk);
        check("shared_act_drained", sb.size(), 0);
        do_reset();

        // Row miss: PRE at ACT+tRAS, ACT at PRE+tRP, RD at ACT+tRCD
        c = cyc;
        set_slot(2, full, read, 2'd2, 2'd3, 16'h0010);
        expect_cmd(activate, 2, c + 1);
        expect_cmd(read_cmd, 2, c + 9);
        repeat (10) @(negedge clk);
        st[2] = returning_data;
        repeat (2) @(negedge clk);
        set_slot(2, full, read, 2'd2, 2'd3, 16'h0020);
        expect_cmd(precharge, 2, c + 21);
        expect_cmd(activate, 2, c + 29);
        expect_cmd(read_cmd, 2, c + 37);
        repeat (35) @(negedge clk);
        check("row_miss_drained", sb.size(), 0);
        do_reset();

        // RD beats a simultaneously ready ACT
        c = cyc;
        set_slot(3, full, read, 2'd0, 2'd0, 16'h0007);
        expect_cmd(activate, 3, c + 1);
        expect_cmd(read_cmd, 3, c + 9);
        repeat (8) @(negedge clk);
        set_slot(1, full, write, 2'd3, 2'd1, 16'h0099);
        expect_cmd(activate, 1, c + 11);
        expect_cmd(write_cmd, 1, c + 19);
        repeat (20) @(negedge clk);
        check("cas_first_drained", sb.size(), 0);
        do_reset();

        // Round-robin from rr_ptr=2 over four row hits
        c = cyc;
        set_slot(1, full, read, 2'd1, 2'd1, 16'h0055);
        expect_cmd(activate, 1, c + 1);
        expect_cmd(read_cmd, 1, c + 9);
        repeat (10) @(negedge clk);
        st[1] = returning_data;
        set_slot(0, full, write, 2'd1, 2'd1, 16'h0055);
        set_slot(2, full, read, 2'd1, 2'd1, 16'h0055);
        set_slot(3, full, write, 2'd1, 2'd1, 16'h0055);
        repeat (2) @(negedge clk);
        st[1] = full;
        expect_cmd(read_cmd, 2, c + 17);
        expect_cmd(write_cmd, 3, c + 25);
        expect_cmd(write_cmd, 0, c + 33);
        expect_cmd(read_cmd, 1, c + 41);
        repeat (40) @(negedge clk);
        check("rr_drained", sb.size(), 0);
        check("idle_cmd", int'(out_burst_cmd), int'(none));
        check("idx_held", int'(out_cmd_index), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
